input_command_queue: RTL
========================

# input_command_queue

Converts the per-button press/release pulses from the debounced button scanners into a stream of game commands for the Tetris game engine. Provides keyboard-style auto-repeat for movement buttons, resolves simultaneous presses by fixed priority, and buffers commands in a small FIFO behind a valid/ready handshake. Sits between the five button scanners and the game-logic state machine.

## Interface
Parameters:
- DAS_DELAY, 25_000_000: clock cycles from the press of a repeatable button to its first repeat (250 ms at 100 MHz); must be ≥ 2.
- REPEAT_PERIOD, 5_000_000: clock cycles between subsequent repeats (50 ms); must be ≥ 2.
- FIFO_DEPTH, 4: command FIFO entries, power of two.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_pressed  in  5  one-cycle press pulses, indexed by command code.
- btn_released  in  5  one-cycle release pulses, same indexing.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_code  out  3  command at FIFO head (0 DROP, 1 ROTATE, 2 LEFT, 3 RIGHT, 4 DOWN).
- cmd_ready  in  1  consumer accepts head this cycle.

## Operation
- Per button: FSM and pending bit. LEFT, RIGHT and DOWN are repeatable. DROP and ROTATE are single-shot.
- FSM states:
  - IDLE. On btn_pressed: set pending, clear counter, go to DELAY.
  - DELAY. Counter increments each cycle. At DAS_DELAY-1: set pending, clear counter, go to REPEAT.
  - REPEAT. At REPEAT_PERIOD-1: set pending, clear counter, stay in REPEAT.
  - Any state on btn_released: go to IDLE and clear the counter. The pending bit is untouched.
- Single-shot buttons: pressed sets pending. Their FSM never leaves IDLE.
- pressed and released in the same cycle: pending is set and the state ends in IDLE.
- An event arriving while pending is already set merges into it. No duplicate command is generated.
- Arbiter: each cycle, if the FIFO can accept, the lowest-index pending bit is written to the FIFO and cleared. At most one push per cycle.
- FIFO can accept when not full, or when full and a pop occurs in the same cycle.
- FIFO is show-ahead:
  - cmd_valid = not empty, and cmd_code = head.
  - Pop when cmd_valid && cmd_ready.
  - cmd_ready with the FIFO empty is ignored.
- Backpressure is lossless: while the FIFO is full, pending bits hold and repeat counters keep running. Repeats that occur during a stall merge into the pending bit.
- Counter width is $clog2(max(DAS_DELAY, REPEAT_PERIOD)) bits. Counters never wrap past their terminal value.

## Timing
- Reset values:
  - Outputs: cmd_valid=0, cmd_code=0.
  - Internal: all FSMs IDLE, pending=0, counters=0, FIFO empty.
  - Reset asserted mid-operation discards all queued and pending commands immediately.
- Latency: a press pulse sampled at edge E sets pending at E. The arbiter pushes at E+1, and cmd_valid is high after E+1. With an empty FIFO, a press is visible two edges after the pulse.
- Holding a repeatable button pressed at edge E yields pushes at E+1, E+1+DAS_DELAY, then every REPEAT_PERIOD cycles (FIFO not full).
- Throughput: one command per cycle, in and out.

## Configuration
- AUTO_REPEAT_EN defined: repeat FSMs and counters exist as described.
- AUTO_REPEAT_EN undefined:
  - All five buttons are single-shot.
  - No counters or DELAY/REPEAT states are synthesized.
  - btn_released is ignored.
  - DAS_DELAY and REPEAT_PERIOD are unused.

## Structure
- Shared package tetris_input_pkg holds:
  - NUM_BUTTONS=5.
  - Command code constants CMD_DROP … CMD_DOWN.
  - REPEATABLE_MASK=5'b11100.
- Sub-module cmd_fifo: synchronous show-ahead FIFO with push/pop/full/empty. It is parameterized by width and depth and uses the same clk/rst.
- Per-button FSMs use a generate loop in the top module.

## Test plan
Bench parameters: DAS_DELAY=10, REPEAT_PERIOD=4.
- Single press: btn_pressed[3] pulse at cycle 0 with cmd_ready=1 -> cmd_valid high for exactly one cycle at cycle 2, cmd_code=3. Release at cycle 5 -> no further commands.
- Auto-repeat: btn_pressed[2] at 0, release at 30, cmd_ready=1 -> LEFT pushes at cycles 1, 11, 15, 19, 23, 27 only.
- Simultaneous press: btn_pressed=5'b10011 at cycle 0 -> commands DROP, ROTATE, DOWN on consecutive cycles.
- Backpressure: cmd_ready=0, six distinct presses -> FIFO holds 4 with cmd_valid=1. Raising cmd_ready delivers all six in priority/arrival order with no loss or duplicates.
- Reset mid-stream: assert rst with 3 queued, button held -> cmd_valid=0 immediately. After release of rst, no commands until a new press.
- AUTO_REPEAT_EN undefined: hold LEFT for 40 cycles -> exactly one command.

Source files
------------

// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris button-to-command path: button count,
// command codes, the repeatable-button mask and the per-button FSM states.
package tetris_input_pkg;

   localparam int NUM_BUTTONS = 5;
   localparam int CMD_W       = 3;

   localparam logic [CMD_W-1:0] CMD_DROP   = 3'd0;
   localparam logic [CMD_W-1:0] CMD_ROTATE = 3'd1;
   localparam logic [CMD_W-1:0] CMD_LEFT   = 3'd2;
   localparam logic [CMD_W-1:0] CMD_RIGHT  = 3'd3;
   localparam logic [CMD_W-1:0] CMD_DOWN   = 3'd4;

   localparam logic [NUM_BUTTONS-1:0] REPEATABLE_MASK = 5'b11100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } btn_state_e;

   // Encodes a one-hot button grant into its command code (zero when no bit is set).
   function automatic logic [CMD_W-1:0] onehot_to_code(input logic [NUM_BUTTONS-1:0] onehot);
      logic [CMD_W-1:0] code;
      code = (onehot[0] ? CMD_DROP   : 3'd0)
           | (onehot[1] ? CMD_ROTATE : 3'd0)
           | (onehot[2] ? CMD_LEFT   : 3'd0)
           | (onehot[3] ? CMD_RIGHT  : 3'd0)
           | (onehot[4] ? CMD_DOWN   : 3'd0);
      return code;
   endfunction

endpackage

// File: rtl/input_command_queue_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO; rdata always presents the head entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             wr_en_s;
   logic             rd_en_s;

   assign full    = (count_r == DEPTH_CNT);
   assign empty   = (count_r == {(AW+1){1'b0}});
   // a full FIFO still takes a write when the head leaves on the same edge
   assign wr_en_s = push && (!full || pop);
   assign rd_en_s = pop && !empty;
   assign rdata   = mem_r[rd_ptr_r];

   // Storage array; cleared on reset so the head reads zero while empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (wr_en_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Read/write pointers and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/input_command_queue.sv
// Turns button press/release pulses into a prioritised, buffered command stream.
// Define AUTO_REPEAT_EN to build the DAS/auto-repeat FSMs for LEFT, RIGHT and DOWN.
module input_command_queue
   import tetris_input_pkg::*;
#(
   parameter int DAS_DELAY     = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BUTTONS-1:0] btn_pressed,
   input  logic [NUM_BUTTONS-1:0] btn_released,
   output logic                   cmd_valid,
   output logic [CMD_W-1:0]       cmd_code,
   input  logic                   cmd_ready
);

   logic [NUM_BUTTONS-1:0] pending_r;
   logic [NUM_BUTTONS-1:0] set_s;
   logic [NUM_BUTTONS-1:0] grant_s;
   logic [NUM_BUTTONS-1:0] clr_s;
   logic                   push_s;
   logic                   pop_s;
   logic [CMD_W-1:0]       push_code_s;
   logic                   fifo_full_s;
   logic                   fifo_empty_s;

   assign cmd_valid = !fifo_empty_s;
   assign pop_s     = cmd_valid && cmd_ready;

   // Fixed-priority arbiter: lowest-index pending button wins (isolate lowest set bit).
   always_comb begin
      grant_s     = pending_r & (~pending_r + NUM_BUTTONS'(1));
      push_s      = (|pending_r) && (!fifo_full_s || pop_s);
      push_code_s = onehot_to_code(grant_s);
      clr_s       = push_s ? grant_s : {NUM_BUTTONS{1'b0}};
   end

   // Pending bits: new events win over the clear so nothing issued this edge is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_r <= {NUM_BUTTONS{1'b0}};
      end else begin
         pending_r <= (pending_r & ~clr_s) | set_s;
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int CNT_MAX = (DAS_DELAY > REPEAT_PERIOD) ? DAS_DELAY : REPEAT_PERIOD;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_PERIOD - 1);
`else
   logic unused_cfg_s;
   assign unused_cfg_s = ^{btn_released, REPEATABLE_MASK, DAS_DELAY, REPEAT_PERIOD};
`endif

   for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
`ifdef AUTO_REPEAT_EN
      if (REPEATABLE_MASK[b]) begin : g_rep
         btn_state_e       state_r;
         btn_state_e       state_nxt_s;
         logic [CNT_W-1:0] cnt_r;
         logic [CNT_W-1:0] cnt_nxt_s;
         logic             tick_s;

         // Repeat FSM state and DAS/repeat counter.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_r <= ST_IDLE;
               cnt_r   <= {CNT_W{1'b0}};
            end else begin
               state_r <= state_nxt_s;
               cnt_r   <= cnt_nxt_s;
            end
         end

         // Next state: release overrides everything, including a repeat due this cycle.
         always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            tick_s      = 1'b0;
            if (btn_released[b]) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               case (state_r)
                  ST_IDLE: begin
                     if (btn_pressed[b]) begin
                        state_nxt_s = ST_DELAY;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                     end else begin
                        state_nxt_s = ST_IDLE;
                     end
                  end
                  ST_DELAY: begin
                     if (cnt_r == DAS_LAST) begin
                        tick_s      = 1'b1;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = ST_REPEAT;
                     end else begin
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                     end
                  end
                  ST_REPEAT: begin
                     if (cnt_r == RPT_LAST) begin
                        tick_s      = 1'b1;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                     end else begin
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                     end
                  end
                  default: begin
                     state_nxt_s = ST_IDLE;
                     cnt_nxt_s   = {CNT_W{1'b0}};
                  end
               endcase
            end
         end

         assign set_s[b] = btn_pressed[b] | tick_s;
      end else begin : g_single
         logic unused_rel_s;
         assign unused_rel_s = btn_released[b];
         assign set_s[b]     = btn_pressed[b];
      end
`else
      assign set_s[b] = btn_pressed[b];
`endif
   end

   cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .wdata (push_code_s),
      .pop   (pop_s),
      .rdata (cmd_code),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

endmodule
